// File: rtl/pipeline_stall_ctrl.sv
// Pipeline freeze/flush controller: prioritises memory stalls, branches and hazards,
// detects memory-wait timeouts and keeps saturating performance counters.
module pipeline_stall_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_output,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_cnt,
   output logic             freeze_if,
   output logic             freeze_id,
   output logic             freeze_exe,
   output logic             freeze_mem,
   output logic             flush_if,
   output logic             flush_id,
   output logic             mem_timeout_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] ERROR    = 2'd2;

   logic [1:0] state_reg, state_next;
   logic [7:0] wait_reg, wait_next;
   logic       err_reg, err_next;
   logic       is_err;
   logic       mem_stall;
   logic       timeout_hit;
   logic       hazard_evt;
   logic       flush_evt;

   // Bit 1 set covers both ERROR and the unreachable encoding 2'd3.
   assign is_err      = state_reg[1];
   assign mem_stall   = mem_req & ~mem_ready & ~is_err;
   assign timeout_hit = mem_stall && (wait_reg == 8'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         wait_reg  <= 8'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      wait_next  = wait_reg;
      err_next   = err_reg;
      case (state_reg)
         RUN, MEM_WAIT: begin
            if (timeout_hit) begin
               state_next = ERROR;
               err_next   = 1'b1;
            end else if (mem_stall) begin
               state_next = MEM_WAIT;
               wait_next  = wait_reg + 8'd1;
            end else begin
               state_next = RUN;
               wait_next  = 8'd0;
            end
         end
         default: state_next = ERROR;
      endcase
   end

   always_comb begin
      freeze_if  = 1'b0;
      freeze_id  = 1'b0;
      freeze_exe = 1'b0;
      freeze_mem = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      if (!rst) begin
         if (is_err || mem_stall) begin
            freeze_if  = 1'b1;
            freeze_id  = 1'b1;
            freeze_exe = 1'b1;
            freeze_mem = 1'b1;
         end else if (branch_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
         end else if (hazard_output) begin
            freeze_if = 1'b1;
            freeze_id = 1'b1;
            flush_id  = 1'b1;
         end
      end
   end

   assign flush_evt  = ~is_err & ~mem_stall & branch_taken;
   assign hazard_evt = ~is_err & ~mem_stall & ~branch_taken & hazard_output;

   assign mem_timeout_err = err_reg;
   assign state           = state_reg;

   // Counter index 0: stall, 1: flush, 2: memory wait.
   logic [2:0]       cnt_evt;
   logic [CNT_W-1:0] cnt_reg [3];

   assign cnt_evt = {mem_stall, flush_evt, hazard_evt};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst || clr_cnt) begin
               cnt_reg[gi] <= '0;
            end else if (cnt_evt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign stall_cnt   = cnt_reg[0];
   assign flush_cnt   = cnt_reg[1];
   assign memwait_cnt = cnt_reg[2];

endmodule
